clock_time_keeper: RTL and testbench

//  Time base and time-setting core of the electric clock. Counts HH:MM:SS in packed BCD from Clk.

---
 rtl/clock_time_keeper_pkg.sv | 24 ++
 rtl/clock_time_keeper_key_debounce.sv | 49 ++++
 rtl/clock_time_keeper.sv | 100 ++++++++++
 tb/tb_clock_time_keeper.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/clock_time_keeper_pkg.sv
// Shared encodings, default timing constants and the BCD increment helper
// used by the clock time keeper and its key debouncers.
package clock_time_keeper_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam logic [3:0] DIGIT_DASH   = 4'hA;
  localparam int         CLK_HZ_DEF   = 50_000_000;
  localparam int         DEB_CNT_DEF  = 999_999;
  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
  localparam logic [7:0] BCD_MS_MAX   = 8'h59;

  // Two-digit packed BCD increment that wraps to 00 after lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)             return 8'h00;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/clock_time_keeper_key_debounce.sv
// Raw active-low key -> synchronised, debounced level -> one-cycle press pulse.
module key_debounce #(
  parameter int DEB_CNT = 999_999
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Key_In,
  output logic Key_Press
);

  localparam int CW = $clog2(DEB_CNT + 1);

  logic          r_sync0, r_sync1;
  logic          r_deb, r_armed, r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge Clk) begin
    r_sync0 <= Key_In;
    r_sync1 <= r_sync0;
  end

  // r_armed stays low until the key is seen released, so a key held
  // through reset cannot produce a press.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_deb   <= 1'b1;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync1) r_armed <= 1'b1;
      if (r_sync1 != r_deb) begin
        if (r_cnt == CW'(DEB_CNT)) begin
          r_deb   <= r_sync1;
          r_cnt   <= '0;
          r_press <= r_armed & ~r_sync1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign Key_Press = r_press;

endmodule

// File: rtl/clock_time_keeper.sv
// HH:MM:SS BCD time base with run/set-hour/set-minute modes and a
// registered 8-nibble display word for the hex8 scanner.
module clock_time_keeper
  import clock_time_keeper_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEF,
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Key_Mode,
  input  logic        Key_Up,
  output logic [31:0] Disp_Data,
  output logic [1:0]  Mode,
  output logic        Sec_Tick
);

  localparam int PW = $clog2(CLK_HZ);

  mode_e         r_state, w_state_nxt;
  logic [PW-1:0] r_pre;
  logic          r_tick;
  logic [7:0]    r_hr, r_min, r_sec;
  logic [31:0]   r_disp;
  logic          w_mode_p, w_up_p, w_up_ev, w_run;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_mode (
    .Clk(Clk), .Reset(Reset), .Key_In(Key_Mode), .Key_Press(w_mode_p)
  );
  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_up (
    .Clk(Clk), .Reset(Reset), .Key_In(Key_Up), .Key_Press(w_up_p)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_p) begin
      case (r_state)
        MODE_RUN:      w_state_nxt = MODE_SET_HOUR;
        MODE_SET_HOUR: w_state_nxt = MODE_SET_MIN;
        default:       w_state_nxt = MODE_RUN;
      endcase
    end
  end

  // Mode press wins over a coincident up press.
  assign w_up_ev = w_up_p & ~w_mode_p;
  assign w_run   = (r_state == MODE_RUN) && (w_state_nxt == MODE_RUN);

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= MODE_RUN;
    else       r_state <= w_state_nxt;
  end

  // Prescaler only runs while staying in RUN, so re-entry gives a full second.
  always_ff @(posedge Clk) begin
    if (Reset || !w_run) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else if (r_pre == PW'(CLK_HZ - 1)) begin
      r_pre  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pre  <= r_pre + 1'b1;
      r_tick <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hr  <= 8'h00;
      r_min <= 8'h00;
      r_sec <= 8'h00;
    end else begin
      case (r_state)
        MODE_RUN: if (r_tick) begin
          r_sec <= bcd_inc(r_sec, BCD_MS_MAX);
          if (r_sec == BCD_MS_MAX) begin
            r_min <= bcd_inc(r_min, BCD_MS_MAX);
            if (r_min == BCD_MS_MAX) r_hr <= bcd_inc(r_hr, BCD_HOUR_MAX);
          end
        end
        MODE_SET_HOUR: if (w_up_ev) r_hr <= bcd_inc(r_hr, BCD_HOUR_MAX);
        default: begin
          if (w_up_ev)  r_min <= bcd_inc(r_min, BCD_MS_MAX);
          if (w_mode_p) r_sec <= 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_disp <= {8'h00, DIGIT_DASH, 8'h00, DIGIT_DASH, 8'h00};
    else       r_disp <= {r_hr, DIGIT_DASH, r_min, DIGIT_DASH, r_sec};
  end

  assign Disp_Data = r_disp;
  assign Mode      = r_state;
  assign Sec_Tick  = r_tick;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed bench for clock_time_keeper with CLK_HZ=10, DEB_CNT=3.
module tb_clock_time_keeper;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Key_Mode = 1'b1;
  logic        Key_Up = 1'b1;
  logic [31:0] Disp_Data;
  logic [1:0]  Mode;
  logic        Sec_Tick;
  int          errs = 0;
  int          checks = 0;

  clock_time_keeper #(.CLK_HZ(10), .DEB_CNT(3)) dut (
    .Clk(Clk), .Reset(Reset), .Key_Mode(Key_Mode), .Key_Up(Key_Up),
    .Disp_Data(Disp_Data), .Mode(Mode), .Sec_Tick(Sec_Tick)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic press(input bit m, input bit u);
    if (m) Key_Mode = 1'b0;
    if (u) Key_Up = 1'b0;
    step(8);
    Key_Mode = 1'b1;
    Key_Up = 1'b1;
    step(8);
  endtask

  task automatic press_up_n(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1);
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 15 && !seen; k++) begin
      step(1);
      if (Sec_Tick) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(3);
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    bit found;

    // Reset state and first-tick latency
    step(3);
    Reset = 1'b0;
    chk("reset_disp", Disp_Data, 32'h00A0_0A00);
    chk("reset_mode", {30'd0, Mode}, 32'd0);
    chk("reset_tick", {31'd0, Sec_Tick}, 32'd0);
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      step(1);
      if (Sec_Tick) n = k;
    end
    chk("first_tick_cycles", n, 10);
    step(1);
    chk("tick_one_cycle", {31'd0, Sec_Tick}, 32'd0);
    step(1);
    chk("disp_one_sec", Disp_Data, 32'h00A0_0A01);

    // SET_HOUR: glitchy press gives exactly one step, then 23->00 wrap
    press(1'b1, 1'b0);
    chk("mode_set_hour", {30'd0, Mode}, 32'd1);
    Key_Up = 1'b0; step(2); Key_Up = 1'b1; step(1);
    Key_Up = 1'b0; step(2); Key_Up = 1'b1; step(1);
    Key_Up = 1'b0; step(8); Key_Up = 1'b1; step(8);
    chk("glitch_one_step", {24'd0, Disp_Data[31:24]}, 32'h01);
    press_up_n(22);
    chk("hour_23", {24'd0, Disp_Data[31:24]}, 32'h23);
    press_up_n(1);
    chk("hour_wrap", Disp_Data[31:8], 32'h00A00A);
    press_up_n(23);
    chk("hour_back_23", {24'd0, Disp_Data[31:24]}, 32'h23);

    // SET_MIN: 59->00 without hour carry
    press(1'b1, 1'b0);
    chk("mode_set_min", {30'd0, Mode}, 32'd2);
    press_up_n(59);
    chk("min_59", Disp_Data[31:8], 32'h23A59A);
    press_up_n(1);
    chk("min_wrap_no_carry", Disp_Data[31:8], 32'h23A00A);
    press_up_n(59);
    chk("min_back_59", Disp_Data[31:8], 32'h23A59A);

    // Exit to RUN with key held: seconds cleared, full second to first tick
    Key_Mode = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if (Mode == 2'd0) found = 1'b1;
    end
    chk("exit_to_run", {31'd0, found}, 32'd1);
    step(1);
    chk("exit_sec_clear", Disp_Data, 32'h23A5_9A00);
    n = 0;
    for (int k = 2; k <= 20 && n == 0; k++) begin
      step(1);
      if (Sec_Tick) n = k;
    end
    chk("restart_full_sec", n, 10);
    chk("held_no_repeat", {30'd0, Mode}, 32'd0);
    Key_Mode = 1'b1;
    for (int k = 0; k < 57; k++) wait_tick("tick_run");
    step(2);
    chk("disp_235958", Disp_Data, 32'h23A5_9A58);
    wait_tick("tick_59");
    step(2);
    chk("disp_235959", Disp_Data, 32'h23A5_9A59);
    wait_tick("tick_wrap");
    step(2);
    chk("day_wrap", Disp_Data, 32'h00A0_0A00);

    // Simultaneous mode+up in SET_HOUR
    do_reset();
    for (int k = 0; k < 3; k++) wait_tick("tick_pre_set");
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    chk("simul_mode", {30'd0, Mode}, 32'd2);
    chk("simul_hour", {24'd0, Disp_Data[31:24]}, 32'h00);
    press(1'b1, 1'b0);
    chk("simul_exit_mode", {30'd0, Mode}, 32'd0);
    chk("simul_exit_disp", Disp_Data, 32'h00A0_0A00);

    // Reset while mode key held in SET_MIN
    do_reset();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("pre_reset_mode", {30'd0, Mode}, 32'd2);
    press_up_n(2);
    Key_Mode = 1'b0;
    step(2);
    do_reset();
    step(8);
    chk("held_reset_mode", {30'd0, Mode}, 32'd0);
    chk("held_reset_disp", Disp_Data, 32'h00A0_0A00);
    step(12);
    chk("held_reset_mode_late", {30'd0, Mode}, 32'd0);
    Key_Mode = 1'b1;
    step(8);
    press(1'b1, 1'b0);
    chk("press_after_release", {30'd0, Mode}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
